// File: rtl/gpio_irq_scheduler_if.sv
// Bus between the GPIO edge detectors / register file / core and the interrupt scheduler.
// master drives detection pulses, mask, clears and ack; slave returns irq and status.
interface gpio_irq_scheduler_if;
    logic [31:0] rising_edge_interrupt_detected;
    logic [31:0] falling_edge_interrupt_detected;
    logic [31:0] irq_mask;
    logic        pending_clr_valid;
    logic [31:0] pending_clr;
    logic        irq_ack;
    logic        irq;
    logic [4:0]  irq_id;
    logic [31:0] pending;
    logic [31:0] overrun;

    modport master (
        output rising_edge_interrupt_detected, falling_edge_interrupt_detected, irq_mask,
               pending_clr_valid, pending_clr, irq_ack,
        input  irq, irq_id, pending, overrun
    );

    modport slave (
        input  rising_edge_interrupt_detected, falling_edge_interrupt_detected, irq_mask,
               pending_clr_valid, pending_clr, irq_ack,
        output irq, irq_id, pending, overrun
    );
endinterface

// File: rtl/gpio_irq_scheduler.sv
// Sticky pending/overrun latching plus a one-at-a-time irq/ack presenter for 32 GPIO pins.
// Define GPIO_IRQ_ROUND_ROBIN_EN for round-robin arbitration; otherwise lowest index wins.
module gpio_irq_scheduler (
    input  logic                       clk,
    input  logic                       rst,
    gpio_irq_scheduler_if.slave        bus
);
    typedef enum logic [1:0] {StIdle, StArb, StActive} state_e;

    state_e      state_q, state_d;
    logic [31:0] pending_q, pending_d;
    logic [31:0] overrun_q, overrun_d;
    logic [4:0]  irq_id_q, irq_id_d;
    logic        irq_q, irq_d;

    logic [31:0] event_w, sw_clr, ack_clr, cand;
    logic        cand_any, ack_hit, clr_hit;
    logic [4:0]  winner;

    assign event_w  = bus.rising_edge_interrupt_detected | bus.falling_edge_interrupt_detected;
    assign sw_clr   = bus.pending_clr_valid ? bus.pending_clr : 32'd0;
    assign cand     = pending_q & ~bus.irq_mask;
    assign cand_any = |cand;
    assign ack_hit  = (state_q == StActive) && bus.irq_ack;
    assign clr_hit  = (state_q == StActive) && sw_clr[irq_id_q];
    assign ack_clr  = ack_hit ? (32'd1 << irq_id_q) : 32'd0;

`ifdef GPIO_IRQ_ROUND_ROBIN_EN
    logic [4:0] rr_q, rr_d;

    // Descending scan so the candidate nearest the pointer overwrites the rest.
    always_comb begin
        logic [4:0] idx;
        winner = 5'd0;
        for (int k = 31; k >= 0; k--) begin
            idx = rr_q + 5'd1 + k[4:0];
            if (cand[idx]) winner = idx;
        end
    end

    assign rr_d = ack_hit ? irq_id_q : rr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rr_q <= 5'd31;
        else     rr_q <= rr_d;
    end
`else
    always_comb begin
        winner = 5'd0;
        for (int k = 31; k >= 0; k--) begin
            if (cand[k]) winner = k[4:0];
        end
    end
`endif

    // Set wins over both software and ack clears.
    always_comb begin
        pending_d = (pending_q & ~(sw_clr | ack_clr)) | event_w;
        overrun_d = (overrun_q & ~sw_clr) | (event_w & pending_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            pending_q <= 32'd0;
            overrun_q <= 32'd0;
            irq_id_q  <= 5'd0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            irq_id_q  <= irq_id_d;
            irq_q     <= irq_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (cand_any) state_d = StArb;
            StArb:    state_d = cand_any ? StActive : StIdle;
            StActive: if (ack_hit || clr_hit) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // irq is registered from the next state so it has no input-to-output path.
    always_comb begin
        irq_d    = (state_d == StActive);
        irq_id_d = irq_id_q;
        if (state_q == StArb && cand_any) irq_id_d = winner;
    end

    assign bus.irq     = irq_q;
    assign bus.irq_id  = irq_id_q;
    assign bus.pending = pending_q;
    assign bus.overrun = overrun_q;
endmodule
